// File: rtl/fir_pkg.sv
// Shared types and defaults for the accurate and approximate FIR variants.
package fir_pkg;

   localparam int NTAPS_DEFAULT = 6;
   localparam int WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE
   } state_t;

   typedef logic signed [WIDTH_DEFAULT-1:0] sample_t;

   // Bring-up taps; element 0 multiplies the newest sample.
   localparam logic [NTAPS_DEFAULT-1:0][WIDTH_DEFAULT-1:0] DEFAULT_COEF = {
      32'sd6, 32'sd5, 32'sd4, 32'sd3, 32'sd2, 32'sd1
   };

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: shift in at tap 0, synchronous clear, all taps exposed.
module fir_delay_line
   import fir_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_shift,
   input  logic                         i_clear,
   input  logic signed [WIDTH-1:0]      i_data,
   output logic [NTAPS-1:0][WIDTH-1:0]  o_taps
);

   logic [NTAPS-1:0][WIDTH-1:0] r_taps;

   // Shift wins over clear; the controller never asserts both.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_taps <= '0;
      end else if (i_shift) begin
         r_taps <= {r_taps[NTAPS-2:0], i_data};
      end else if (i_clear) begin
         r_taps <= '0;
      end
   end

   assign o_taps = r_taps;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed 6-tap FIR controller driving one shared external multiplier.
module fir_tap_sequencer
   import fir_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter logic [NTAPS-1:0][WIDTH-1:0] COEF = DEFAULT_COEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic                    clear,
   output logic signed [WIDTH-1:0] mul_a,
   output logic signed [WIDTH-1:0] mul_b,
   input  logic signed [WIDTH-1:0] mul_p,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_data,
   output logic                    busy
);

   localparam int TW = $clog2(NTAPS);
   localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);

   state_t                    r_state;
   logic [TW-1:0]             r_tap;
   logic signed [WIDTH-1:0]   r_acc;
   logic [NTAPS-1:0][WIDTH-1:0] w_taps;
   logic                      w_idle;
   logic                      w_mac;
   logic                      w_shift;
   logic                      w_clear;

   assign w_idle  = (r_state == IDLE);
   assign w_mac   = (r_state == MAC);
   assign w_shift = w_idle && in_valid;
   assign w_clear = w_idle && !in_valid && clear;

   fir_delay_line #(
      .NTAPS (NTAPS),
      .WIDTH (WIDTH)
   ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_shift (w_shift),
      .i_clear (w_clear),
      .i_data  (in_data),
      .o_taps  (w_taps)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tap   <= '0;
         r_acc   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_tap   <= '0;
                  r_state <= MAC;
               end
            end
            MAC: begin
               // Tap 0 restarts the sum so no separate acc clear is needed.
               r_acc <= (r_tap == '0) ? mul_p : r_acc + mul_p;
               if (r_tap == LAST_TAP) begin
                  r_state <= DONE;
               end else begin
                  r_tap <= r_tap + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = w_idle;
   assign busy      = w_mac;
   assign out_valid = (r_state == DONE);
   assign out_data  = r_acc;
   assign mul_a     = w_mac ? w_taps[r_tap] : '0;
   assign mul_b     = w_mac ? COEF[r_tap] : '0;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized self-checking bench against a sum-of-products reference model.
module tb_fir_tap_sequencer;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_data;
   logic               clear;
   logic signed [31:0] mul_a;
   logic signed [31:0] mul_b;
   logic signed [31:0] mul_p;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] out_data;
   logic               busy;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] coef_m [6];
   logic [31:0] hist   [6];

   fir_tap_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .clear     (clear),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   assign mul_p = mul_a * mul_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_out();
      logic [31:0] s = '0;
      for (int k = 0; k < 6; k++) s = s + coef_m[k] * hist[k];
      return s;
   endfunction

   task automatic model_push(input logic [31:0] x);
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
   endtask

   task automatic model_zero();
      for (int k = 0; k < 6; k++) hist[k] = '0;
   endtask

   // Offer one sample, wait for its result, stall stall cycles, consume it.
   task automatic send(input logic [31:0] x, input int stall,
                       input logic with_clear);
      int cyc;
      logic [31:0] exp;
      logic [31:0] held;
      @(negedge clk);
      chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = x;
      clear    = with_clear;
      @(posedge clk);
      model_push(x);
      exp = model_out();
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         chk("busy_mac", {31'b0, busy}, 32'd1);
         chk("in_ready_mac", {31'b0, in_ready}, 32'd0);
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, 32'd7);
      chk("out_data", out_data, exp);
      chk("mul_a_done", mul_a, 32'd0);
      held = out_data;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         @(negedge clk);
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_data", out_data, held);
         chk("in_ready_done", {31'b0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("after_take", {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      int cyc;
      logic [31:0] x;
      for (int k = 0; k < 6; k++) coef_m[k] = 32'(k + 1);
      model_zero();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'd99;
      clear     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_mul_a", mul_a, 32'd0);
      chk("rst_mul_b", mul_b, 32'd0);

      // Impulse response
      send(32'd1, 0, 1'b0);
      for (int i = 0; i < 5; i++) send(32'd0, 0, 1'b0);

      // Step with backpressure
      for (int i = 0; i < 6; i++) send(32'd10, 5, 1'b0);

      // Clear in IDLE, then clear ignored alongside a sample
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      model_zero();
      @(negedge clk);
      clear = 1'b0;
      send(32'd5, 0, 1'b0);
      send(32'd7, 1, 1'b1);

      // Wrap-around and negative input
      for (int i = 0; i < 6; i++) send(32'h7FFF_FFFF, 0, 1'b0);
      send(-32'sd3, 0, 1'b0);

      // Reset during MAC tap 3
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'd55;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      model_zero();
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) cyc++;
         @(negedge clk);
      end
      chk("abort_no_valid", cyc, 32'd0);
      send(32'd1, 0, 1'b0);
      send(32'd0, 0, 1'b0);

      // Random samples, stalls and occasional clears
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            clear = 1'b1;
            @(posedge clk);
            model_zero();
            @(negedge clk);
            clear = 1'b0;
         end
         x = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
         send(x, $urandom_range(0, 3), 1'($urandom_range(0, 5) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
